id_decode_queue: RTL and testbench

Parametrised RV32 instruction-decode stage with a built-in instruction queue and a multi-source WFI sleep controller. It sits between IF and EX. It buffers fetched instructions, decodes the head entry into opcode, funct fields, register tags and immediate, and holds issue while a WFI is sleeping. It wakes on any enabled pending interrupt and counts the sleep cycles.

---
 rtl/id_decode_queue.sv | 168 ++++++++++++++++
 tb/tb_id_decode_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_queue.sv
// RV32 decode stage: circular instruction queue, combinational head decode and
// a two-state WFI sleep controller with a saturating sleep-cycle counter.
module id_decode_queue #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned NIRQ   = 2,
  parameter int unsigned CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [5:0]      rs1_tag,
  output logic [5:0]      rs2_tag,
  output logic [5:0]      rd_tag,
  output logic [31:0]     imm,
  output logic [31:0]     out_pc,
  output logic            is_mret,
  input  logic [NIRQ-1:0] irq_pending,
  input  logic [NIRQ-1:0] irq_enable,
  input  logic            flush,
  output logic            sleeping,
  output logic            wake,
  output logic [CNTW-1:0] sleep_cycles
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QDEPTH);
  localparam logic [31:0] WFI_C   = 32'h1050_0073;
  localparam logic [31:0] MRET_C  = 32'h3020_0073;

  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_FSW   = 7'b0100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_FALU  = 7'b1010011;

  typedef enum logic {
    RUN,
    SLEEP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     instr_mem_q [QDEPTH];
  logic [31:0]     pc_mem_q    [QDEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CNTW-1:0] sleep_cnt_q, sleep_cnt_d;

  logic        empty, full, enq, deq, irq_any;
  logic [31:0] head_instr;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign irq_any   = |(irq_pending & irq_enable);
  assign in_ready  = !full && !flush;
  assign out_valid = !empty && (state_q == RUN);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign sleeping  = (state_q == SLEEP);
  assign sleep_cycles = sleep_cnt_q;

  // Forcing the head word to zero when empty makes every decoded field zero.
  assign head_instr = empty ? '0 : instr_mem_q[rd_ptr_q];

  always_comb begin
    logic fp_rs1, fp_rs2, fp_rd;
    opcode  = head_instr[6:0];
    funct3  = head_instr[14:12];
    funct7  = head_instr[31:25];
    fp_rs1  = (opcode == OP_FALU);
    fp_rs2  = (opcode == OP_FALU) || (opcode == OP_FSW);
    fp_rd   = (opcode == OP_FALU) || (opcode == OP_FLW);
    rs1_tag = {fp_rs1, head_instr[19:15]};
    rs2_tag = {fp_rs2, head_instr[24:20]};
    rd_tag  = {fp_rd,  head_instr[11:7]};
    is_mret = (head_instr == MRET_C);
    out_pc  = empty ? '0 : pc_mem_q[rd_ptr_q];
    case (opcode)
      OP_OPIMM, OP_LOAD, OP_FLW, OP_JALR:
        imm = {{20{head_instr[31]}}, head_instr[31:20]};
      OP_STORE, OP_FSW:
        imm = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      OP_BR:
        imm = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
               head_instr[30:25], head_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {head_instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
               head_instr[20], head_instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sleep_cnt_d = sleep_cnt_q;
    wake        = 1'b0;

    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    case (state_q)
      RUN: begin
        // A WFI retired with an interrupt already pending acts as a NOP.
        if (deq && (head_instr == WFI_C) && !irq_any && !flush) begin
          state_d     = SLEEP;
          sleep_cnt_d = '0;
        end
      end
      SLEEP: begin
        wake = irq_any;
        if (sleep_cnt_q != '1) sleep_cnt_d = sleep_cnt_q + 1'b1;
        if (irq_any || flush) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sleep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sleep_cnt_q <= sleep_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: directed scenarios plus random traffic, all
// outputs compared each cycle against a queue-based reference model.
module tb_id_decode_queue;

  localparam int unsigned QDEPTH = 4;
  localparam int unsigned NIRQ   = 2;
  localparam int unsigned CNTW   = 5;
  localparam int          MAXC   = (1 << CNTW) - 1;
  localparam logic [31:0] WFI    = 32'h1050_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [31:0]     in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [5:0]      rs1_tag, rs2_tag, rd_tag;
  logic [31:0]     imm;
  logic [31:0]     out_pc;
  logic            is_mret;
  logic [NIRQ-1:0] irq_pending;
  logic [NIRQ-1:0] irq_enable;
  logic            flush;
  logic            sleeping;
  logic            wake;
  logic [CNTW-1:0] sleep_cycles;

  id_decode_queue #(.QDEPTH(QDEPTH), .NIRQ(NIRQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rd_tag(rd_tag),
    .imm(imm), .out_pc(out_pc), .is_mret(is_mret),
    .irq_pending(irq_pending), .irq_enable(irq_enable), .flush(flush),
    .sleeping(sleeping), .wake(wake), .sleep_cycles(sleep_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {pc, instr}, sleep flag, sleep counter.
  logic [63:0] mq[$];
  bit          msleep = 1'b0;
  int          mcnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    logic [31:0] sh;
    case (w[6:0])
      7'h13, 7'h03, 7'h07, 7'h67: begin
        sh = $signed(w) >>> 20;
        return sh;
      end
      7'h23, 7'h27: begin
        sh = $signed(w) >>> 20;
        return (sh & ~32'h1f) | ((w >> 7) & 32'h1f);
      end
      7'h63: begin
        sh = $signed(w) >>> 19;
        return (sh & 32'hFFFF_F000) | (((w >> 7) & 32'h1) << 11)
             | (((w >> 25) & 32'h3f) << 5) | (((w >> 8) & 32'hf) << 1);
      end
      7'h37, 7'h17: return w & 32'hFFFF_F000;
      7'h6F: begin
        sh = $signed(w) >>> 11;
        return (sh & 32'hFFF0_0000) | (w & 32'h000F_F000)
             | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3ff) << 1);
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs();
    logic [31:0] w, p;
    bit fr1, fr2, frd, irq_any;
    w = 32'h0;
    p = 32'h0;
    if (mq.size() != 0) begin
      w = mq[0][31:0];
      p = mq[0][63:32];
    end
    irq_any = |(irq_pending & irq_enable);
    fr1 = (w[6:0] == 7'h53);
    fr2 = (w[6:0] == 7'h53) || (w[6:0] == 7'h27);
    frd = (w[6:0] == 7'h53) || (w[6:0] == 7'h07);
    check_eq("in_ready", in_ready, (mq.size() < QDEPTH) && !flush);
    check_eq("out_valid", out_valid, (mq.size() != 0) && !msleep);
    check_eq("sleeping", sleeping, msleep);
    check_eq("wake", wake, msleep && irq_any);
    check_eq("sleep_cycles", sleep_cycles, mcnt);
    check_eq("opcode", opcode, w[6:0]);
    check_eq("funct3", funct3, w[14:12]);
    check_eq("funct7", funct7, w[31:25]);
    check_eq("rs1_tag", rs1_tag, {fr1, w[19:15]});
    check_eq("rs2_tag", rs2_tag, {fr2, w[24:20]});
    check_eq("rd_tag", rd_tag, {frd, w[11:7]});
    check_eq("imm", imm, ref_imm(w));
    check_eq("out_pc", out_pc, p);
    check_eq("is_mret", is_mret, w == MRET);
  endtask

  task automatic model_clock();
    bit irq_any, rdy, ov, enq, deq, was_sleep;
    logic [63:0] head;
    irq_any   = |(irq_pending & irq_enable);
    rdy       = (mq.size() < QDEPTH) && !flush;
    ov        = (mq.size() != 0) && !msleep;
    enq       = in_valid && rdy;
    deq       = ov && out_ready;
    was_sleep = msleep;
    if (was_sleep && mcnt < MAXC) mcnt++;
    if (flush) begin
      mq.delete();
      msleep = 1'b0;
    end else begin
      if (deq) begin
        head = mq.pop_front();
        if (head[31:0] == WFI && !irq_any) begin
          msleep = 1'b1;
          mcnt   = 0;
        end
      end
      if (enq) mq.push_back({in_pc, in_instr});
      if (was_sleep && irq_any) msleep = 1'b0;
    end
  endtask

  // Called shortly after a rising edge with inputs already driven.
  task automatic step();
    #3;
    check_outputs();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input logic [NIRQ-1:0] pend,
                        input logic [NIRQ-1:0] en, input bit fl);
    in_valid    = v;
    in_instr    = ins;
    in_pc       = pc;
    out_ready   = ordy;
    irq_pending = pend;
    irq_enable  = en;
    flush       = fl;
  endtask

  task automatic reset_checks();
    check_eq("rst_out_valid", out_valid, 32'h0);
    check_eq("rst_in_ready", in_ready, 32'h1);
    check_eq("rst_sleeping", sleeping, 32'h0);
    check_eq("rst_wake", wake, 32'h0);
    check_eq("rst_sleep_cycles", sleep_cycles, 32'h0);
    check_eq("rst_opcode", opcode, 32'h0);
    check_eq("rst_imm", imm, 32'h0);
    check_eq("rst_rd_tag", rd_tag, 32'h0);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, '0, '0, 0);
    rst = 1'b1;
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    msleep = 1'b0;
    mcnt   = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 15))
      0:  w[6:0] = 7'h13;
      1:  w[6:0] = 7'h03;
      2:  w[6:0] = 7'h07;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h23;
      5:  w[6:0] = 7'h27;
      6:  w[6:0] = 7'h63;
      7:  w[6:0] = 7'h37;
      8:  w[6:0] = 7'h17;
      9:  w[6:0] = 7'h6F;
      10: w[6:0] = 7'h53;
      11: w = WFI;
      12: w = MRET;
      13: w[6:0] = 7'h73;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [NIRQ-1:0] en_r;
    set_in(0, 0, 0, 0, '0, '0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;

    // Basic decode: addi, fadd.s, sw
    set_in(1, 32'h0050_0093, 32'h100, 0, '0, '0, 0);
    step();
    check_eq("addi_valid", out_valid, 32'h1);
    check_eq("addi_opcode", opcode, 32'h13);
    check_eq("addi_rd", rd_tag, 32'h01);
    check_eq("addi_rs1", rs1_tag, 32'h00);
    check_eq("addi_imm", imm, 32'h5);
    check_eq("addi_pc", out_pc, 32'h100);
    set_in(1, 32'h0020_81D3, 32'h104, 1, '0, '0, 0);
    step();
    check_eq("fadd_rs1", rs1_tag, 32'h21);
    check_eq("fadd_rs2", rs2_tag, 32'h22);
    check_eq("fadd_rd", rd_tag, 32'h23);
    check_eq("fadd_imm", imm, 32'h0);
    set_in(1, 32'hFE11_2E23, 32'h108, 1, '0, '0, 0);
    step();
    check_eq("sw_rs2", rs2_tag, 32'h01);
    check_eq("sw_imm", imm, 32'hFFFF_FFFC);
    set_in(0, 0, 0, 1, '0, '0, 0);
    repeat (2) step();

    // Fill to full, fifth word waits for a dequeue, order across wrap
    for (int i = 0; i < 5; i++) begin
      set_in(1, 32'h0000_0093 | (i << 20), 32'h400 + 4 * i, 0, '0, '0, 0);
      step();
      if (i == 3) check_eq("full_in_ready", in_ready, 32'h0);
    end
    set_in(1, 32'h0040_0093, 32'h410, 1, '0, '0, 0);
    repeat (2) step();
    set_in(0, 0, 0, 1, '0, '0, 0);
    repeat (5) step();

    // WFI sleep, wake only on an enabled source
    set_in(1, WFI, 32'h200, 0, 2'b00, 2'b01, 0);
    step();
    set_in(1, 32'h0050_0093, 32'h204, 0, 2'b00, 2'b01, 0);
    step();
    set_in(0, 0, 0, 1, 2'b00, 2'b01, 0);
    step();
    check_eq("wfi_sleeping", sleeping, 32'h1);
    check_eq("wfi_out_valid", out_valid, 32'h0);
    repeat (10) step();
    set_in(0, 0, 0, 1, 2'b10, 2'b01, 0);
    repeat (3) step();
    set_in(0, 0, 0, 1, 2'b01, 2'b01, 0);
    #1;
    check_eq("wake_pulse", wake, 32'h1);
    step();
    check_eq("woke_sleeping", sleeping, 32'h0);
    check_eq("woke_sleep_cycles", sleep_cycles, 32'd14);
    check_eq("woke_out_valid", out_valid, 32'h1);
    check_eq("woke_pc", out_pc, 32'h204);
    set_in(0, 0, 0, 1, 2'b00, 2'b01, 0);
    repeat (2) step();

    // WFI with an interrupt already pending is a NOP; MRET detection
    set_in(1, WFI, 32'h300, 1, 2'b01, 2'b01, 0);
    step();
    set_in(1, MRET, 32'h304, 1, 2'b01, 2'b01, 0);
    step();
    check_eq("nop_wfi_sleeping", sleeping, 32'h0);
    check_eq("mret_valid", out_valid, 32'h1);
    check_eq("mret_flag", is_mret, 32'h1);
    set_in(0, 0, 0, 1, '0, '0, 0);
    step();

    // Flush with three queued entries and a simultaneous enqueue
    for (int i = 0; i < 3; i++) begin
      set_in(1, rand_instr(), 32'h500 + 4 * i, 0, '0, '0, 0);
      step();
    end
    set_in(1, 32'h0050_0093, 32'h50C, 1, '0, '0, 1);
    step();
    set_in(0, 0, 0, 0, '0, '0, 0);
    #1;
    check_eq("flush_out_valid", out_valid, 32'h0);
    check_eq("flush_in_ready", in_ready, 32'h1);
    step();

    // Flush during sleep
    set_in(1, WFI, 32'h600, 1, 2'b00, 2'b01, 0);
    step();
    set_in(1, 32'h0050_0093, 32'h604, 1, 2'b00, 2'b01, 0);
    step();
    check_eq("fsleep_sleeping", sleeping, 32'h1);
    set_in(1, 32'h0010_0113, 32'h608, 1, 2'b00, 2'b01, 0);
    repeat (3) step();
    set_in(0, 0, 0, 1, 2'b00, 2'b01, 1);
    #1;
    check_eq("fsleep_wake", wake, 32'h0);
    step();
    check_eq("fsleep_exit", sleeping, 32'h0);
    check_eq("fsleep_empty", out_valid, 32'h0);

    // Counter saturation, then reset mid-sleep
    set_in(1, WFI, 32'h700, 1, 2'b00, 2'b01, 0);
    step();
    set_in(0, 0, 0, 1, 2'b00, 2'b01, 0);
    repeat (41) step();
    check_eq("sat_sleep_cycles", sleep_cycles, MAXC);
    check_eq("sat_sleeping", sleeping, 32'h1);
    do_reset();

    // Random traffic
    en_r = 2'b01;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) en_r = NIRQ'($urandom);
      if (c == 800) do_reset();
      set_in($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 9) < 6,
             ($urandom_range(0, 7) == 0) ? NIRQ'($urandom) : '0,
             en_r, $urandom_range(0, 29) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
